// File: rtl/rx_sipo_pkg.sv
// Shared types and constants for the SerDes receive SIPO/aligner family.
package rx_sipo_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } align_state_e;

  localparam logic [9:0] K28_5_NEG = 10'h17C;
  localparam logic [9:0] K28_5_POS = 10'h283;

  // Lock/miss counters stick at all-ones rather than wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/rx_sipo_aligner_comma_detect.sv
// Combinational comma matcher: flags a window equal to either comma polarity.
module rx_comma_detect #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] nxt_i,
  input  logic [WIDTH-1:0] pat_neg_i,
  input  logic [WIDTH-1:0] pat_pos_i,
  output logic             is_comma_o
);

  assign is_comma_o = (nxt_i == pat_neg_i) || (nxt_i == pat_pos_i);

endmodule

// File: rtl/rx_sipo_aligner.sv
// Serial-to-parallel converter with K28.5 comma word alignment.
// state  | meaning
// HUNT   | no boundary yet; any comma realigns
// VERIFY | boundary chosen; counting boundary commas toward lock
// LOCKED | boundary fixed; off-boundary commas counted toward loss of lock
module rx_sipo_aligner
  import rx_sipo_pkg::*;
#(
  parameter int               WIDTH      = 10,
  parameter logic [WIDTH-1:0] COMMA_NEG  = WIDTH'(K28_5_NEG),
  parameter logic [WIDTH-1:0] COMMA_POS  = WIDTH'(K28_5_POS),
  parameter int               LOCK_COUNT = 3,
  parameter int               MISS_LIMIT = 4
) (
  input  logic             BitCLK,
  input  logic             Reset,
  input  logic             Serial,
  input  logic             align_en,
  output logic [WIDTH-1:0] RxParallel,
  output logic             rx_valid,
  output logic             comma_det,
  output logic             aligned
);

  localparam int              CW     = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST   = CW'(WIDTH - 1);
  localparam logic [3:0]      LOCK_N = 4'(LOCK_COUNT);
  localparam logic [3:0]      MISS_N = 4'(MISS_LIMIT);

  align_state_e     state_q, state_d;
  logic [WIDTH-1:0] win_q, nxt;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [3:0]       good_q, good_d;
  logic [3:0]       miss_q, miss_d;
  logic [WIDTH-1:0] rx_par_q;
  logic             rx_valid_q, comma_det_q;
  logic             is_comma, boundary, realign, emit;
  logic [3:0]       good_inc, miss_inc;

  assign nxt      = {Serial, win_q[WIDTH-1:1]};
  assign boundary = (bit_cnt_q == LAST);
  assign good_inc = sat_inc(good_q);
  assign miss_inc = sat_inc(miss_q);

  rx_comma_detect #(.WIDTH(WIDTH)) u_comma (
    .nxt_i      (nxt),
    .pat_neg_i  (COMMA_NEG),
    .pat_pos_i  (COMMA_POS),
    .is_comma_o (is_comma)
  );

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    miss_d  = miss_q;
    realign = 1'b0;
    if (align_en && is_comma) begin
      case (state_q)
        HUNT: begin
          realign = 1'b1;
          good_d  = 4'd1;
          miss_d  = 4'd0;
          state_d = (LOCK_N == 4'd1) ? LOCKED : VERIFY;
        end
        VERIFY: begin
          if (boundary) begin
            good_d = good_inc;
            if (good_inc >= LOCK_N) begin
              state_d = LOCKED;
              miss_d  = 4'd0;
            end
          end else begin
            realign = 1'b1;
            good_d  = 4'd1;
          end
        end
        LOCKED: begin
          if (boundary) begin
            miss_d = 4'd0;
          end else if (miss_inc >= MISS_N) begin
            state_d = HUNT;
            good_d  = 4'd0;
            miss_d  = 4'd0;
          end else begin
            miss_d = miss_inc;
          end
        end
        default: state_d = HUNT;
      endcase
    end
    // A realign landing on the boundary is indistinguishable from a boundary word.
    emit      = boundary || realign;
    bit_cnt_d = emit ? '0 : bit_cnt_q + CW'(1);
  end

  always_ff @(posedge BitCLK) begin
    if (!Reset) begin
      state_q     <= HUNT;
      win_q       <= '0;
      bit_cnt_q   <= '0;
      good_q      <= 4'd0;
      miss_q      <= 4'd0;
      rx_par_q    <= '0;
      rx_valid_q  <= 1'b0;
      comma_det_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= nxt;
      bit_cnt_q   <= bit_cnt_d;
      good_q      <= good_d;
      miss_q      <= miss_d;
      rx_valid_q  <= emit;
      comma_det_q <= emit && is_comma;
      if (emit) rx_par_q <= nxt;
    end
  end

  assign RxParallel = rx_par_q;
  assign rx_valid   = rx_valid_q;
  assign comma_det  = comma_det_q;
  assign aligned    = (state_q == LOCKED);

endmodule

// File: tb/tb_rx_sipo_aligner.sv
// Directed plus random bench for rx_sipo_aligner against a bit-history reference model.
module tb_rx_sipo_aligner;

  localparam int         W    = 10;
  localparam int         LOCK = 3;
  localparam int         MISS = 4;
  localparam logic [9:0] CN   = 10'h17C;
  localparam logic [9:0] CP   = 10'h283;
  localparam logic [9:0] DAT  = 10'h155;

  logic       BitCLK = 1'b0;
  logic       Reset = 1'b0;
  logic       Serial = 1'b0;
  logic       align_en = 1'b1;
  logic [9:0] RxParallel;
  logic       rx_valid, comma_det, aligned;

  int errors = 0;
  int checks = 0;

  rx_sipo_aligner #(
    .WIDTH(W), .COMMA_NEG(CN), .COMMA_POS(CP), .LOCK_COUNT(LOCK), .MISS_LIMIT(MISS)
  ) dut (
    .BitCLK(BitCLK), .Reset(Reset), .Serial(Serial), .align_en(align_en),
    .RxParallel(RxParallel), .rx_valid(rx_valid), .comma_det(comma_det), .aligned(aligned)
  );

  always #5 BitCLK = ~BitCLK;

  // Reference model: last W received bits, edges since reset, edge of last realign.
  bit         hist[$];
  int         n_edges, anchor, mode, good, miss;
  logic [9:0] m_data;
  bit         m_valid, m_cd;

  function automatic logic [9:0] last_word();
    logic [9:0] w;
    int idx;
    for (int i = 0; i < W; i++) begin
      idx = hist.size() - W + i;
      w[i] = (idx >= 0) ? hist[idx] : 1'b0;
    end
    return w;
  endfunction

  task automatic model_reset();
    hist.delete();
    n_edges = 0; anchor = 0; mode = 0; good = 0; miss = 0;
    m_data = '0; m_valid = 0; m_cd = 0;
  endtask

  task automatic model_edge(input bit s, input bit en);
    logic [9:0] w;
    bit is_c, on_b, moved;
    hist.push_back(s);
    if (hist.size() > W) void'(hist.pop_front());
    n_edges++;
    w     = last_word();
    is_c  = (w == CN) || (w == CP);
    on_b  = ((n_edges - anchor) % W) == 0;
    moved = 0;
    if (en && is_c) begin
      if (mode == 0) begin
        moved = 1; good = 1; miss = 0;
        mode = (LOCK == 1) ? 2 : 1;
      end else if (mode == 1) begin
        if (on_b) begin
          good = (good < 15) ? good + 1 : 15;
          if (good >= LOCK) begin mode = 2; miss = 0; end
        end else begin
          moved = 1; good = 1;
        end
      end else begin
        if (on_b) miss = 0;
        else begin
          miss = (miss < 15) ? miss + 1 : 15;
          if (miss >= MISS) begin mode = 0; good = 0; miss = 0; end
        end
      end
    end
    if (moved) anchor = n_edges;
    m_valid = on_b || moved;
    if (m_valid) m_data = w;
    m_cd = m_valid && is_c;
  endtask

  task automatic chk(input string tag, input logic [9:0] got, input logic [9:0] want);
    checks++;
    assert (got === want)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"}, {9'd0, rx_valid}, {9'd0, m_valid});
    chk({tag, ".data"}, RxParallel, m_data);
    chk({tag, ".cdet"}, {9'd0, comma_det}, {9'd0, m_cd});
    chk({tag, ".aligned"}, {9'd0, aligned}, {9'd0, (mode == 2)});
  endtask

  task automatic step(input bit s, input bit en, input string tag);
    Reset = 1'b1; Serial = s; align_en = en;
    @(posedge BitCLK);
    model_edge(s, en);
    #1;
    check_all(tag);
  endtask

  task automatic rst_step(input bit s, input string tag);
    Reset = 1'b0; Serial = s;
    @(posedge BitCLK);
    model_reset();
    #1;
    check_all(tag);
    chk({tag, ".zero"}, {RxParallel[9:1], RxParallel[0] | rx_valid | comma_det | aligned}, 10'd0);
  endtask

  task automatic send_word(input logic [9:0] w, input bit en, input string tag);
    for (int i = 0; i < W; i++) step(w[i], en, tag);
  endtask

  task automatic pad_to_boundary(input bit en);
    while (((n_edges - anchor) % W) != 0) step(1'b0, en, "pad");
  endtask

  initial begin
    model_reset();
    align_en = 1'b1;

    // Reset held for two edges with toggling data
    rst_step(1'b1, "rst0");
    rst_step(1'b0, "rst1");

    // First word exactly 10 edges after release
    for (int i = 0; i < W - 1; i++) step(DAT[i], 1'b1, "first");
    chk("first_quiet", {9'd0, rx_valid}, 10'd0);
    step(DAT[W-1], 1'b1, "first");
    chk("first_pulse", {9'd0, rx_valid}, 10'd1);

    // Offset alignment: 3 junk bits then commas
    step(1'b1, 1'b1, "junk"); step(1'b0, 1'b1, "junk"); step(1'b1, 1'b1, "junk");
    send_word(CN, 1'b1, "c1");
    chk("realign_pulse", {9'd0, rx_valid}, 10'd1);
    chk("realign_data", RxParallel, CN);
    chk("realign_cdet", {9'd0, comma_det}, 10'd1);
    send_word(CP, 1'b1, "c2");
    chk("c2_unaligned", {9'd0, aligned}, 10'd0);
    send_word(CN, 1'b1, "c3");
    chk("c3_aligned", {9'd0, aligned}, 10'd1);
    send_word(DAT, 1'b1, "data");
    chk("data_word", RxParallel, DAT);
    chk("data_cdet", {9'd0, comma_det}, 10'd0);

    // Loss of lock: four commas each shifted by one more bit
    for (int k = 0; k < MISS; k++) begin
      step(1'b0, 1'b1, "shift");
      send_word(CN, 1'b1, "miss");
      if (k < MISS - 1) chk("miss_hold", {9'd0, aligned}, 10'd1);
    end
    chk("lock_lost", {9'd0, aligned}, 10'd0);
    send_word(CP, 1'b1, "rehunt");
    chk("rehunt_pulse", {9'd0, rx_valid}, 10'd1);
    chk("rehunt_data", RxParallel, CP);
    send_word(CN, 1'b1, "relock");
    send_word(CP, 1'b1, "relock");
    chk("relocked", {9'd0, aligned}, 10'd1);

    // Miss recovery: an aligned comma between shifted bursts keeps lock
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, "shift"); send_word(CN, 1'b1, "rec_a"); end
    pad_to_boundary(1'b1);
    send_word(CP, 1'b1, "rec_mid");
    for (int k = 0; k < 3; k++) begin step(1'b0, 1'b1, "shift"); send_word(CN, 1'b1, "rec_b"); end
    chk("recovery_locked", {9'd0, aligned}, 10'd1);

    // Frozen in LOCKED: shifted commas with align_en=0 never lose lock
    for (int k = 0; k < 6; k++) begin step(1'b0, 1'b0, "frz"); send_word(CN, 1'b0, "frz"); end
    chk("frozen_locked", {9'd0, aligned}, 10'd1);

    // Reset mid-word while locked at bit_cnt = 6
    pad_to_boundary(1'b1);
    for (int i = 0; i < 6; i++) step(DAT[i], 1'b1, "mid");
    rst_step(1'b1, "rst_mid");

    // align_en=0 in HUNT: comma at 5-bit offset is ignored, old boundary kept
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "off5");
    send_word(CN, 1'b0, "noalign");
    chk("noalign_pulse", {9'd0, rx_valid}, 10'd0);
    chk("noalign_state", {9'd0, aligned}, 10'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "oldb");
    chk("old_boundary", {9'd0, rx_valid}, 10'd1);

    // Random traffic with commas at random offsets
    for (int it = 0; it < 300; it++) begin
      bit en;
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 9) < 2)
        send_word($urandom_range(0, 1) ? CN : CP, en, "rnd_c");
      else
        step(1'($urandom_range(0, 1)), en, "rnd_b");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
